alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 27 ++
 rtl/mul_seq.sv | 50 +++++
 rtl/alu_seq.sv | 123 ++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and enums for the sequential ALU.
// ALU_MUL_EN adds the MUL state to the FSM encoding.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 11;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_DONE = 2'd3
  } alu_state_t;

endpackage

// File: rtl/mul_seq.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, LSB first.
// Only the low WIDTH bits of the product are kept.
module mul_seq #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             run;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) run <= 1'b0;
    end
  end

  assign product = acc;
  assign done    = (cnt == CW'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/carry and a flags-register write strobe.
// Define ALU_MUL_EN to include the multi-cycle shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  alu_reset,
  input  logic                  alu_start,
  input  logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_carry,
  output logic                  alu_busy,
  output logic                  alu_done,
  output logic                  flags_wr
);

  alu_state_t            state, state_nxt;
  alu_op_t               op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH:0]   sum, diff;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_c;
  logic                  start_acc;

  assign start_acc = (state == S_IDLE) && alu_start;

`ifdef ALU_MUL_EN
  logic [DATA_WIDTH-1:0] mul_product;
  logic                  mul_done;

  mul_seq #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clock),
    .rst     (alu_reset),
    .start   (start_acc && (alu_op_t'(alu_op) == OP_MUL)),
    .a       (alu_a),
    .b       (alu_b),
    .product (mul_product),
    .done    (mul_done)
  );
`endif

  // NOTE: operand holding registers carry no reset; they are only read after
  // a start edge has loaded them, so a reset term would buy nothing.
  always_ff @(posedge clock) begin
    if (start_acc) begin
      op_q <= alu_op_t'(alu_op);
      a_q  <= alu_a;
      b_q  <= alu_b;
    end
  end

  // Extra top bit gives carry-out for ADD and unsigned borrow for SUB.
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD: begin res = sum[DATA_WIDTH-1:0];  res_c = sum[DATA_WIDTH];  end
      OP_SUB: begin res = diff[DATA_WIDTH-1:0]; res_c = diff[DATA_WIDTH]; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_SHL: begin res = {a_q[DATA_WIDTH-2:0], 1'b0}; res_c = a_q[DATA_WIDTH-1]; end
`ifdef ALU_MUL_EN
      OP_MUL: res = mul_product;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (alu_start) begin
`ifdef ALU_MUL_EN
          state_nxt = (alu_op_t'(alu_op) == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: state_nxt = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_done) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result registers load only on entry to DONE and otherwise hold.
  always_ff @(posedge clock or posedge alu_reset) begin
    if (alu_reset) begin
      state     <= S_IDLE;
      alu_out   <= '0;
      alu_carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_DONE) begin
        alu_out   <= res;
        alu_carry <= res_c;
      end
    end
  end

`ifdef ALU_MUL_EN
  assign alu_busy = (state == S_EXEC) || (state == S_MUL);
`else
  assign alu_busy = (state == S_EXEC);
`endif
  assign alu_done = (state == S_DONE);
  assign flags_wr = alu_done;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops
// against an arithmetic reference model. Honours ALU_MUL_EN like the RTL.
module tb_alu_seq;

  localparam int W       = 11;
  localparam int LAT_MAX = 40;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clock;
  logic         alu_reset;
  logic         alu_start;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_out;
  logic         alu_carry, alu_busy, alu_done, flags_wr;

  int n_checks = 0;
  int n_fails  = 0;

  alu_seq dut (
    .clock     (clock),
    .alu_reset (alu_reset),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_busy  (alu_busy),
    .alu_done  (alu_done),
    .flags_wr  (flags_wr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [2:0] op,
                                       input longint unsigned a,
                                       input longint unsigned b);
    longint unsigned m, r;
    logic c;
    m = 64'd1 << W;
    r = 0;
    c = 1'b0;
    case (op)
      3'd0: begin r = a + b; c = (r >= m); r = r % m; end
      3'd1: begin c = (a < b); r = (a + m - b) % m; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = m - 1 - a;
      3'd6: begin c = (a >= m / 2); r = (2 * a) % m; end
      default: r = MUL_EN ? (a * b) % m : 0;
    endcase
    return {c, r[W-1:0]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_out"},   alu_out,   '0);
    check({tag, "_carry"}, alu_carry, 0);
    check({tag, "_busy"},  alu_busy,  0);
    check({tag, "_done"},  alu_done,  0);
    check({tag, "_fwr"},   flags_wr,  0);
  endtask

  // Issues one op (called #1 after a rising edge, DUT idle) and checks
  // latency, busy, the one-cycle done pulse and the held result.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag);
    logic [W:0] exp;
    int lat_exp, k;
    bit got;
    exp     = model(op, a, b);
    lat_exp = (op == 3'd7 && MUL_EN) ? W + 1 : 1;
    alu_start = 1'b1;
    alu_op    = op;
    alu_a     = a;
    alu_b     = b;
    @(posedge clock); #1;
    alu_start = 1'b0;
    alu_op    = 3'($urandom);
    alu_a     = W'($urandom);
    alu_b     = W'($urandom);
    check({tag, "_busy_first"}, alu_busy, 1);
    check({tag, "_done_early"}, alu_done, 0);
    got = 1'b0;
    k = 0;
    while (!got && k < LAT_MAX) begin
      @(posedge clock); #1;
      k++;
      if (alu_done) got = 1'b1;
      else check({tag, "_busy"}, alu_busy, 1);
    end
    check({tag, "_latency"}, got ? k : -1, lat_exp);
    check({tag, "_out"},     alu_out,   exp[W-1:0]);
    check({tag, "_carry"},   alu_carry, exp[W]);
    check({tag, "_fwr"},     flags_wr,  1);
    check({tag, "_busy_done"}, alu_busy, 0);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, alu_done, 0);
    check({tag, "_fwr_pulse"},  flags_wr, 0);
    check({tag, "_hold"},       alu_out,  exp[W-1:0]);
  endtask

  initial begin
    int dones;
    logic [W-1:0] seen;
    logic [2:0] rop;

    alu_reset = 1'b1;
    alu_start = 1'b0;
    alu_op    = 3'd0;
    alu_a     = '0;
    alu_b     = '0;
    #12;
    check_zero("reset");
    @(posedge clock); #1;
    alu_reset = 1'b0;

    // First edge after reset release must accept the start.
    run_op(3'd0, 11'h7FF, 11'h001, "add_wrap");
    check("add_wrap_zero", alu_out, 11'h000);
    check("add_wrap_cout", alu_carry, 1);
    run_op(3'd1, 11'd5, 11'd7, "sub_borrow");
    check("sub_neg", alu_out, 11'h7FE);
    run_op(3'd7, 11'd3, 11'd5, "mul_3x5");
    check("mul_3x5_val", alu_out, MUL_EN ? 11'd15 : 11'd0);
    run_op(3'd7, 11'h400, 11'd2, "mul_ovf");
    run_op(3'd6, 11'h555, 11'd0, "shl_msb");
    run_op(3'd5, 11'h0F0, 11'd0, "not");
    run_op(3'd1, 11'd9, 11'd9, "sub_eq");

    // A start arriving while an op is in flight must be dropped.
    alu_start = 1'b1; alu_op = 3'd7; alu_a = 11'd3; alu_b = 11'd5;
    @(posedge clock); #1;
    alu_start = 1'b0;
    dones = 0;
    seen  = '1;
    @(posedge clock); #1;
    if (alu_done) begin dones++; seen = alu_out; end
    alu_start = 1'b1; alu_op = 3'd0; alu_a = 11'd1; alu_b = 11'd1;
    @(posedge clock); #1;
    alu_start = 1'b0;
    if (alu_done) begin dones++; seen = alu_out; end
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (alu_done) begin dones++; seen = alu_out; end
    end
    check("ignore_dones", dones, 1);
    check("ignore_out", seen, MUL_EN ? 11'd15 : 11'd0);

    // Reset in the middle of a multiply.
    alu_start = 1'b1; alu_op = 3'd7; alu_a = 11'd3; alu_b = 11'd5;
    @(posedge clock); #1;
    alu_start = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clock);
    #3;
    alu_reset = 1'b1;
    #1;
    check_zero("abort");
    @(posedge clock); #1;
    alu_reset = 1'b0;
    run_op(3'd0, 11'd2, 11'd2, "post_abort");
    check("post_abort_val", alu_out, 11'd4);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (alu_done) dones++;
    end
    check("abort_no_done", dones, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, W'($urandom), W'($urandom), $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
